pulse_word_decoder: RTL and testbench
=====================================

Name: pulse_word_decoder

Overview:
- Receive-side counterpart of the delay-line memory manager's serial transmitter.
- Recovers the return-to-zero pulse train coming back out of the delay line:
  - each bit slot is pulse_gap low cycles, then a pulse_width window that is high for a 1 and stays low for a 0.
- Re-phases its slot timing on pulse edges, frames bits into DATA_WIDTH-bit words and tags each word with its circulating address.
- Presents each word to the host-side logic over a valid/ack handshake with sticky overrun.

Parameters:
DATA_WIDTH, 16, bits per word (same as replace-number data width)
ADDR_WIDTH, 8, word address / no_nums width
PW_WIDTH, 8, width of pulse_width port
PG_WIDTH, 8, width of pulse_gap port
OFFSET_WIDTH, 8, width of bit_offset port

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
run  input  1  synchronous enable; low = hold in IDLE, clear all state and flags
in  input  1  raw delay-line output
pulse_width  input  PW_WIDTH  high-window length in clk cycles
pulse_gap  input  PG_WIDTH  low-gap length in clk cycles
no_nums  input  ADDR_WIDTH  number of words circulating
bit_offset  input  OFFSET_WIDTH  slots to discard after lock before bit 0 of word 0
word_data  output  DATA_WIDTH  received word, first-received bit = MSB
word_addr  output  ADDR_WIDTH  address of word_data
word_valid  output  1  word_data/word_addr valid
word_ack  input  1  consumer has taken the word
overrun  output  1  sticky: word replaced before ack
locked  output  1  slot timing established
edge_error  output  1  one-cycle strobe: rising edge outside the expected phase window

Behaviour:
- n_reset low (async) or run low (sync):
  - state IDLE; all outputs 0; counters 0.
  - Config ports must be stable while run is high.
- Input path: 2-FF synchroniser, then edge detect. Rising edge = sync'd level 0->1. All timings below are relative to the synchronised signal (2-cycle latency).
- Slot length L = pulse_width + pulse_gap.
- slot_ctr counts 0..L-1 and wraps.
- Sample point: slot_ctr == pulse_gap + pulse_width/2 (integer divide).
- States:
  - IDLE -> WAIT_EDGE when run is high.
  - WAIT_EDGE: on the first rising edge, load slot_ctr <= pulse_gap, set locked, go to SKIP (or RECV if bit_offset == 0).
  - If pulse_width == 0, stay in WAIT_EDGE indefinitely.
  - SKIP: count bit_offset sample points, discarding them, then go to RECV.
  - RECV: shift the sampled level into the word at each sample point.
    - After DATA_WIDTH samples, on the next clk: word_data <= assembled word, word_addr <= addr_ctr, word_valid <= 1.
    - addr_ctr then advances, wrapping to 0 after no_nums-1. no_nums 0 or 1 => addr_ctr always 0.
- Re-phase, in SKIP/RECV:
  - Rising edge with |slot_ctr - pulse_gap| <= 1: reload slot_ctr <= pulse_gap.
  - Any other rising edge: edge_error pulses for 1 cycle; no reload; data still sampled normally.
- Zero bits produce no edges; timing free-runs across them.
- Handshake:
  - word_valid stays high until the clk edge where word_ack is high, then clears.
  - New word while word_valid is high and word_ack is low: data and address are overwritten, word_valid stays 1, overrun <= 1.
  - overrun stays set until run is low.
  - New word and word_ack in the same cycle: new word is loaded, word_valid stays 1, overrun unchanged.
  - word_ack while word_valid is low: ignored.
- run dropping mid-word: partial word is discarded, no word_valid.

Optional Feature:
- Macro: PULSE_WORD_DECODER_GLITCH_FILTER_EN.
- Defined:
  - A 3-sample majority filter follows the synchroniser (+2 cycles latency).
  - The sample-point value is the majority of the samples at sample point -1, 0 and +1.
- Undefined: single sample at the sample point, no filter; isolated 1-cycle glitches pass through.

Test Plan:
- pw=4, pg=4, no_nums=3, offset=0, stream 0xA5C3, 0x0001, 0xFFFF, 0x8000 -> words in order with addr 0, 1, 2, 0; each acked; overrun stays 0.
- offset=5, 5 junk slots then 0x1234 -> first word 0x1234, addr 0; junk not reported.
- Two words, no ack -> word_data = second word, overrun = 1; ack -> word_valid = 0, overrun still 1 until run low.
- Transmitter period 9 cycles vs decoder L=8, word 0xFFFF -> re-phase keeps all bits correct; edge_error = 0. Edge injected at slot_ctr = pulse_gap+3 -> edge_error = 1 for one cycle.
- run dropped after 7 bits, then re-raised -> locked = 0, no word_valid; next full word decoded at addr 0.
- With filter enabled: 1-cycle high glitch in the middle of a 0-bit high window -> bit reads 0; filter undefined -> bit reads 1.

Source files
------------

// File: rtl/pulse_word_decoder.sv
// Receive side of the delay-line serial link: recovers return-to-zero pulse words, tags them with an address.
// Define PULSE_WORD_DECODER_GLITCH_FILTER_EN to add a 3-sample majority filter behind the input synchroniser.
module pulse_word_decoder #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int PW_WIDTH     = 8,
    parameter int PG_WIDTH     = 8,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    run,
    input  logic                    in,
    input  logic [PW_WIDTH-1:0]     pulse_width,
    input  logic [PG_WIDTH-1:0]     pulse_gap,
    input  logic [ADDR_WIDTH-1:0]   no_nums,
    input  logic [OFFSET_WIDTH-1:0] bit_offset,
    output logic [DATA_WIDTH-1:0]   word_data,
    output logic [ADDR_WIDTH-1:0]   word_addr,
    output logic                    word_valid,
    input  logic                    word_ack,
    output logic                    overrun,
    output logic                    locked,
    output logic                    edge_error
);

    localparam int CW  = ((PW_WIDTH > PG_WIDTH) ? PW_WIDTH : PG_WIDTH) + 1;
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, SKIP, RECV} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              sync_ff;
    logic                    lvl;
    logic                    lvl_d;
    logic                    rise;
    logic [CW-1:0]           slot_ctr;
    logic [CW-1:0]           slot_len;
    logic [CW-1:0]           ctr_adv;
    logic [CW-1:0]           gap_ext;
    logic [CW-1:0]           sample_pt;
    logic [CW-1:0]           ctr_dist;
    logic                    in_window;
    logic                    at_sample;
    logic                    skip_done;
    logic [OFFSET_WIDTH-1:0] skip_ctr;
    logic [BCW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    word_done;
    logic [ADDR_WIDTH-1:0]   addr_ctr;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_ff <= '0;
        end else if (!run) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[0], in};
        end
    end

`ifdef PULSE_WORD_DECODER_GLITCH_FILTER_EN
    logic [1:0] filt_hist;
    logic       filt_lvl;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            filt_hist <= '0;
            filt_lvl  <= 1'b0;
        end else if (!run) begin
            filt_hist <= '0;
            filt_lvl  <= 1'b0;
        end else begin
            filt_hist <= {filt_hist[0], sync_ff[1]};
            filt_lvl  <= (sync_ff[1] & filt_hist[0]) | (sync_ff[1] & filt_hist[1]) |
                         (filt_hist[0] & filt_hist[1]);
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync_ff[1];
`endif

    // lvl_d is the timing reference: slot_ctr == pulse_gap on its first high cycle after an edge
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lvl_d <= 1'b0;
        end else if (!run) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;

    // An edge is judged against the count the slot timer would advance to on this cycle
    always_comb begin
        slot_len  = CW'(pulse_width) + CW'(pulse_gap);
        gap_ext   = CW'(pulse_gap);
        sample_pt = gap_ext + CW'(pulse_width >> 1);
        ctr_adv   = (slot_ctr >= slot_len - CW'(1)) ? '0 : slot_ctr + CW'(1);
        ctr_dist  = (ctr_adv >= gap_ext) ? (ctr_adv - gap_ext) : (gap_ext - ctr_adv);
        in_window = (ctr_dist <= CW'(1));
        at_sample = (slot_ctr == sample_pt);
        skip_done = at_sample && (skip_ctr == bit_offset - OFFSET_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = WAIT_EDGE;
                WAIT_EDGE: if (rise && (pulse_width != '0))
                               state_nxt = (bit_offset == '0) ? RECV : SKIP;
                SKIP:      if (skip_done) state_nxt = RECV;
                default:   state_nxt = state;
            endcase
        end
    end

    always_comb begin
        locked = (state == SKIP) || (state == RECV);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            slot_ctr   <= '0;
            edge_error <= 1'b0;
            skip_ctr   <= '0;
        end else if (!run) begin
            slot_ctr   <= '0;
            edge_error <= 1'b0;
            skip_ctr   <= '0;
        end else begin
            edge_error <= 1'b0;
            case (state)
                WAIT_EDGE: slot_ctr <= (rise && (pulse_width != '0)) ? gap_ext : '0;
                SKIP, RECV: begin
                    slot_ctr <= (rise && in_window) ? gap_ext : ctr_adv;
                    if (rise && !in_window) edge_error <= 1'b1;
                end
                default:   slot_ctr <= '0;
            endcase
            if (state == SKIP && at_sample) skip_ctr <= skip_ctr + OFFSET_WIDTH'(1);
        end
    end

    // Bit framing: the finished word is handed over one clock after its last sample
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else if (!run) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (state == RECV && at_sample) begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], lvl_d};
                if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            word_data  <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
            addr_ctr   <= '0;
        end else if (!run) begin
            word_data  <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
            addr_ctr   <= '0;
        end else if (word_done) begin
            word_data  <= shift_reg;
            word_addr  <= addr_ctr;
            word_valid <= 1'b1;
            if (word_valid && !word_ack) overrun <= 1'b1;
            if ((no_nums <= ADDR_WIDTH'(1)) || (addr_ctr >= no_nums - ADDR_WIDTH'(1)))
                addr_ctr <= '0;
            else
                addr_ctr <= addr_ctr + ADDR_WIDTH'(1);
        end else if (word_ack) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_word_decoder.sv
// Bench for pulse_word_decoder: builds RZ waveforms, scoreboards the decoded words and checks the corner cases.
`timescale 1ns/1ps
module tb_pulse_word_decoder;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        run;
    logic        in_line;
    logic [7:0]  pulse_width;
    logic [7:0]  pulse_gap;
    logic [7:0]  no_nums;
    logic [7:0]  bit_offset;
    logic [15:0] word_data;
    logic [7:0]  word_addr;
    logic        word_valid;
    logic        word_ack;
    logic        overrun;
    logic        locked;
    logic        edge_error;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    bit   wave[$];
    int   total = 0;
    int   bad = 0;
    int   err_cycles = 0;

    pulse_word_decoder dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .run         (run),
        .in          (in_line),
        .pulse_width (pulse_width),
        .pulse_gap   (pulse_gap),
        .no_nums     (no_nums),
        .bit_offset  (bit_offset),
        .word_data   (word_data),
        .word_addr   (word_addr),
        .word_valid  (word_valid),
        .word_ack    (word_ack),
        .overrun     (overrun),
        .locked      (locked),
        .edge_error  (edge_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (edge_error === 1'b1) err_cycles++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void addSlot(input bit b, input int pg, input int pw);
        for (int i = 0; i < pg; i++) wave.push_back(1'b0);
        for (int i = 0; i < pw; i++) wave.push_back(b);
    endfunction

    function automatic void queueWord(input logic [15:0] w, input logic [15:0] exp_data,
                                      input logic [7:0] addr, input int pg, input int pw);
        exp_t e;
        for (int i = 15; i >= 0; i--) addSlot(w[i], pg, pw);
        e.data = exp_data;
        e.addr = addr;
        exp_q.push_back(e);
    endfunction

    task automatic playWave();
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            in_line = wave[i];
        end
        @(negedge clk);
        in_line = 1'b0;
        wave.delete();
    endtask

    task automatic waitValid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (word_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic consumeWords(input int n);
        for (int k = 0; k < n; k++) begin
            bit   ok;
            exp_t e;
            waitValid(400, ok);
            checkOutput("valid_seen", 32'(ok), 1);
            if (ok) begin
                checkOutput("queue_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("word_data", 32'(word_data), 32'(e.data));
                    checkOutput("word_addr", 32'(word_addr), 32'(e.addr));
                end
                checkOutput("no_overrun", 32'(overrun), 0);
                word_ack = 1'b1;
                @(negedge clk);
                word_ack = 1'b0;
                checkOutput("valid_cleared", 32'(word_valid), 0);
            end
        end
    endtask

    task automatic beginRun(input int pg, input int pw, input int nn, input int off);
        @(negedge clk);
        run = 1'b0;
        exp_q.delete();
        pulse_gap   = 8'(pg);
        pulse_width = 8'(pw);
        no_nums     = 8'(nn);
        bit_offset  = 8'(off);
        repeat (2) @(negedge clk);
        run = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input exp_t vecs[4]);
        for (int i = 0; i < 4; i++) queueWord(vecs[i].data, vecs[i].data, vecs[i].addr, 4, 4);
        fork
            playWave();
            consumeWords(4);
        join
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t vecs[4];
        int   err_snap;
        exp_t e;

        vecs[0] = '{data: 16'hA5C3, addr: 8'd0};
        vecs[1] = '{data: 16'h0001, addr: 8'd1};
        vecs[2] = '{data: 16'hFFFF, addr: 8'd2};
        vecs[3] = '{data: 16'h8000, addr: 8'd0};

        n_reset = 1'b0;
        run = 1'b0;
        in_line = 1'b0;
        word_ack = 1'b0;
        pulse_width = 8'd4;
        pulse_gap = 8'd4;
        no_nums = 8'd3;
        bit_offset = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(word_valid), 0);
        checkOutput("rst_data", 32'(word_data), 0);
        checkOutput("rst_addr", 32'(word_addr), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        checkOutput("rst_locked", 32'(locked), 0);
        checkOutput("rst_edge_error", 32'(edge_error), 0);
        n_reset = 1'b1;

        $display("[TB] four words, address wrap at no_nums=3");
        beginRun(4, 4, 3, 0);
        err_snap = err_cycles;
        applyStimulus(vecs);
        checkOutput("stream_edge_error", 32'(err_cycles - err_snap), 0);
        checkOutput("stream_overrun", 32'(overrun), 0);

        $display("[TB] bit_offset=5 discards junk slots");
        beginRun(4, 4, 3, 5);
        addSlot(1'b1, 4, 4);
        addSlot(1'b0, 4, 4);
        addSlot(1'b1, 4, 4);
        addSlot(1'b1, 4, 4);
        addSlot(1'b0, 4, 4);
        queueWord(16'h1234, 16'h1234, 8'd0, 4, 4);
        fork
            playWave();
            consumeWords(1);
        join

        $display("[TB] two words without ack");
        beginRun(4, 4, 3, 0);
        queueWord(16'hC3A5, 16'hC3A5, 8'd0, 4, 4);
        queueWord(16'h5AF0, 16'h5AF0, 8'd1, 4, 4);
        playWave();
        repeat (12) @(negedge clk);
        e = exp_q.pop_front();
        e = exp_q.pop_front();
        checkOutput("ovr_valid", 32'(word_valid), 1);
        checkOutput("ovr_data", 32'(word_data), 32'(e.data));
        checkOutput("ovr_addr", 32'(word_addr), 32'(e.addr));
        checkOutput("ovr_flag", 32'(overrun), 1);
        word_ack = 1'b1;
        @(negedge clk);
        word_ack = 1'b0;
        checkOutput("ovr_ack_valid", 32'(word_valid), 0);
        checkOutput("ovr_sticky", 32'(overrun), 1);
        run = 1'b0;
        @(negedge clk);
        checkOutput("ovr_cleared", 32'(overrun), 0);
        checkOutput("ovr_unlocked", 32'(locked), 0);

        $display("[TB] 9-cycle transmitter against 8-cycle slot");
        beginRun(4, 4, 3, 0);
        queueWord(16'hFFFF, 16'hFFFF, 8'd0, 5, 4);
        err_snap = err_cycles;
        fork
            playWave();
            consumeWords(1);
        join
        checkOutput("rephase_edge_error", 32'(err_cycles - err_snap), 0);

        $display("[TB] stray edge late in a zero slot");
        beginRun(4, 4, 3, 0);
        queueWord(16'h8000, 16'h8000, 8'd0, 4, 4);
        wave[31] = 1'b1;
        wave[32] = 1'b1;
        wave[33] = 1'b1;
        err_snap = err_cycles;
        fork
            playWave();
            consumeWords(1);
        join
        checkOutput("stray_edge_error_cycles", 32'(err_cycles - err_snap), 1);

        $display("[TB] run dropped mid-word");
        beginRun(4, 4, 3, 0);
        for (int i = 0; i < 7; i++) addSlot(1'b1, 4, 4);
        playWave();
        repeat (4) @(negedge clk);
        checkOutput("partial_locked", 32'(locked), 1);
        checkOutput("partial_no_valid", 32'(word_valid), 0);
        run = 1'b0;
        @(negedge clk);
        checkOutput("drop_locked", 32'(locked), 0);
        checkOutput("drop_valid", 32'(word_valid), 0);
        repeat (3) @(negedge clk);
        run = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("rerun_locked", 32'(locked), 0);
        checkOutput("rerun_valid", 32'(word_valid), 0);
        queueWord(16'hB00B, 16'hB00B, 8'd0, 4, 4);
        fork
            playWave();
            consumeWords(1);
        join

        $display("[TB] one-cycle glitch in a zero window");
        beginRun(4, 4, 3, 0);
`ifdef PULSE_WORD_DECODER_GLITCH_FILTER_EN
        queueWord(16'h8001, 16'h8001, 8'd0, 4, 4);
`else
        queueWord(16'h8001, 16'h8081, 8'd0, 4, 4);
`endif
        wave[70] = 1'b1;
        fork
            playWave();
            consumeWords(1);
        join

        run = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
